// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO drain-side stream reader.
// Occupancy encoding, output buffer depth, and the FIFO read latency the reader is built around.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int BUF_DEPTH  = 2;
  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/rd_skid_buffer.sv
// Two-entry head/skid buffer: data captured at the edge, head drives the stream next cycle.
// Holds head stable while not popped; a pop with the skid occupied promotes the skid at the same edge.
module rd_skid_buffer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output occ_e                  occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  valid
);

  occ_e                  occ_nxt;
  logic [DATA_WIDTH-1:0] skid_data;

  always_ff @(posedge clk) begin
    if (!rst_n) occ <= OCC_EMPTY;
    else        occ <= occ_nxt;
  end

  always_comb begin
    occ_nxt = occ;
    unique case (occ)
      OCC_EMPTY: if (cap) occ_nxt = OCC_ONE;
      OCC_ONE: begin
        if (cap && !pop)      occ_nxt = OCC_TWO;
        else if (pop && !cap) occ_nxt = OCC_EMPTY;
      end
      OCC_TWO:   if (pop) occ_nxt = OCC_ONE;
      default:   occ_nxt = OCC_EMPTY;
    endcase
  end

  always_comb begin
    valid = (occ != OCC_EMPTY);
  end

  // Incoming word lands in head only if head is free after this pop and nothing older waits in skid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_data <= '0;
      skid_data <= '0;
    end else begin
      if (pop && occ == OCC_TWO) head_data <= skid_data;
      if (cap) begin
        if (occ == OCC_EMPTY || (occ == OCC_ONE && pop)) head_data <= cap_data;
        else                                              skid_data <= cap_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(cap && occ == OCC_TWO && !pop));
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream; first beat 2 cycles after a non-empty FIFO.
// Full throughput, at most 2 words held under backpressure; FIFO_RD_LAST_EN adds m_last framing every PKT_LEN beats.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef FIFO_RD_LAST_EN
  output logic                  m_last,
`endif
  output logic [DATA_WIDTH-1:0] m_data
);

  occ_e       occ;
  logic       pend;
  logic       pop;
  logic [2:0] fill;

  assign pop = m_valid & m_ready;

  // Words held plus the one in flight, after this cycle's pop, must leave room for another read.
  always_comb begin
    fill      = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
    fifo_r_en = rst_n & ~fifo_empty & (fill < 3'(BUF_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= fifo_r_en;
  end

  rd_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap       (pend),
    .cap_data  (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data),
    .valid     (m_valid)
  );

`ifdef FIFO_RD_LAST_EN
  localparam int CNT_W = $clog2(PKT_LEN) + 1;

  logic [CNT_W-1:0] beat_cnt;

  assign m_last = m_valid && (beat_cnt == CNT_W'(PKT_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)      beat_cnt <= '0;
    else if (pop)    beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
  end
`endif

  // The pend pipeline is a single flop, so it only matches a one-cycle FIFO read latency.
  always_ff @(posedge clk) begin
    if (rst_n) assert (PKT_LEN >= 1 && RD_LATENCY == 1);
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drain-side companion to the team's synchronous FIFO.
- Pulls words from the FIFO read port (r_en/empty, registered data one cycle after an accepted read) and presents them as a valid/ready stream.
- A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, so the stream runs at full throughput with no loss or reordering under backpressure.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- PKT_LEN, 4, beats per packet; used only when FIFO_RD_LAST_EN is defined; must be >= 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO registered read data, valid the cycle after fifo_r_en.
- fifo_r_en  output  1  FIFO read enable.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  end of packet; port present only with FIFO_RD_LAST_EN.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - While rst_n=0: fifo_r_en forced 0 combinationally.
  - At the first edge with rst_n=0: m_valid=0, m_data=0, m_last=0, occupancy=0, pend=0, beat counter=0.
- State:
  - occ in {EMPTY(0), ONE(1), TWO(2)}: buffer entries held.
  - pend: 1 when a read was issued last cycle and its data arrives this cycle.
  - Entries are head (drives m_data) and skid.
- pop = m_valid & m_ready.
- Read issue rule:
  - fifo_r_en = rst_n & !fifo_empty & ((occ + pend - pop) < 2).
  - This is combinational from fifo_empty and m_ready.
  - Never asserted while fifo_empty=1.
- pend_next = fifo_r_en.
- Capture: when pend=1, fifo_data is written at the edge.
  - Goes to head if the head is free after this cycle's pop and the skid is empty.
  - Otherwise goes to the skid.
- Pop with skid occupied: skid moves to head at the same edge.
- Transitions:
  - EMPTY: +capture -> ONE.
  - ONE: capture&!pop -> TWO; pop&!capture -> EMPTY; both or neither -> ONE.
  - TWO: pop -> ONE. Capture in TWO without pop is impossible by the issue rule; assert this in simulation.
- m_valid = (occ != 0), registered.
- m_data/m_valid are held stable while m_valid=1 & m_ready=0.
- Latency:
  - fifo_empty falls in cycle 0 with buffer empty -> fifo_r_en=1 in cycle 0 -> data captured at end of cycle 1 -> m_valid=1 in cycle 2.
- Throughput: 1 beat/cycle sustained when the FIFO is non-empty and m_ready=1.
- Order: strict FIFO order; no duplication, no drop.
- Backpressure: at most 2 words buffered plus 0 in flight when the downstream is stalled. Total (occ+pend) never exceeds 2.
- Reset mid-operation: in-flight read and buffered words are discarded. The FIFO shares rst_n and empties too.

Optional Feature:
- Macro: FIFO_RD_LAST_EN.
- Defined:
  - Beat counter of width $clog2(PKT_LEN)+1, counting accepted beats (pop).
  - m_last=1 when the head beat is beat PKT_LEN-1 of its packet, i.e. counter==PKT_LEN-1 and m_valid=1.
  - Counter wraps to 0 on a pop with m_last=1.
  - Counter resets to 0.
- Undefined: no m_last port, no counter logic; stream is unframed.

Decomposition:
- Package fifo_rd_pkg:
  - occ_e enum (OCC_EMPTY, OCC_ONE, OCC_TWO).
  - localparam BUF_DEPTH=2.
  - localparam RD_LATENCY=1.
- Sub-module rd_skid_buffer holds the head/skid registers and the occ state machine.
  - Inputs: capture strobe, data, pop.
  - Outputs: occ, head data, valid.
- Top holds the issue rule, pend and the optional beat counter.

Test Plan:
- Reset: FIFO preloaded with 3 words, rst_n=0 for 2 cycles -> fifo_r_en=0, m_valid=0, m_data=0 throughout; after release, first read is issued the same cycle.
- Streaming: FIFO holds 0x01..0x05, m_ready=1 constant -> m_valid rises 2 cycles after reset release; 0x01..0x05 appear on 5 consecutive cycles; fifo_r_en never high with fifo_empty=1.
- Backpressure: 4 words 0xA0..0xA3 queued, m_ready=0 for 6 cycles -> exactly 2 reads issued; m_data=0xA0 held stable. m_ready then high -> 0xA0..0xA3 delivered in order with no gap.
- Alternating ready: m_ready toggles 1/0 every cycle with 8 words queued -> all 8 delivered in order, each held until accepted; occ+pend never exceeds 2.
- Mid-operation reset: rst_n=0 while occ=TWO and pend=0 -> next cycle m_valid=0, occ=EMPTY; no stale word appears after release.
- FIFO_RD_LAST_EN with PKT_LEN=4: 8 beats streamed -> m_last=1 on beats 4 and 8 only. A stall on beat 4 keeps m_last=1 until accepted.
